serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Sequencing controller for the team's 1-bit adder cell. It accepts two WIDTH-bit operands on a start request and feeds them to a single full-adder cell one bit per cycle, LSB first, carrying between cycles. It presents a registered WIDTH-bit sum plus carry-out with a busy/done handshake. It sits between a requesting master and the shared bit-level adder datapath, trading WIDTH+1 cycles of latency for one adder cell.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.
CNT_W, derived as max(1, $clog2(WIDTH)); width of the bit-index counter; not overridable.

Ports:
clk    input   1      single system clock, rising edge
rst    input   1      asynchronous, active-high reset
start  input   1      request; sampled only in IDLE
a      input   WIDTH  operand A; sampled on the accepting edge only
b      input   WIDTH  operand B; sampled on the accepting edge only
busy   output  1      high while in RUN
done   output  1      one-cycle pulse, high while in DONE
sum    output  WIDTH  registered result; held until the next completion
cout   output  1      registered carry-out; held until the next completion

Behaviour:
- Reset, asynchronous and active-high: state=IDLE, busy=0, done=0, sum=0, cout=0. Operand shift registers, carry register, partial-sum register and counter are all cleared. Reset asserted mid-RUN aborts the operation with no done pulse, and sum/cout read 0.
- States: IDLE, RUN, DONE, encoded as a 2-bit state register.
- IDLE:
  - If start=1 at a clock edge: latch a into opa and b into opb, carry=0, cnt=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, on each edge:
  - s = opa[0]^opb[0]^carry; carry = majority(opa[0], opb[0], carry).
  - s shifts into the MSB of the partial-sum register, which shifts right.
  - opa and opb shift right; cnt increments.
  - On the edge where cnt==WIDTH-1, the full result (shifted-in bit included) loads into sum, the final carry loads into cout, and state goes to DONE.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE. start is ignored in DONE.
- Latency: with the accepting edge at E0, done is high in the cycle after edge E0+WIDTH. sum/cout are valid from that same edge.
- Throughput: with start held high, one operation every WIDTH+2 cycles.
- start is ignored in RUN and DONE. a and b may change freely after the accepting edge without affecting the result.
- sum/cout change only at the completion edge. They are stable in IDLE, RUN and DONE otherwise, so the previous result stays readable during a new operation.
- Width rule: {cout,sum} equals a+b modulo 2^(WIDTH+1) exactly; there are no overflow exceptions.
- WIDTH=1: RUN lasts exactly one edge, since cnt==0==WIDTH-1 on the first RUN edge.
- Outputs busy and done decode directly from the state register (registered, glitch-free). There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package serial_adder_pkg holds:
  - the state typedef/localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the default WIDTH constant.
- One sub-module, fa_cell: purely combinational 1-bit full adder, inputs x, y, ci and outputs s, co. Built from two half-adder stages plus an OR. Instantiated once; the controller owns all registers.

Test Plan:
- WIDTH=8, start one cycle with a=0x00, b=0x00 -> busy high 8 cycles, done pulse in the cycle after edge E0+8, sum=0x00, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1; full carry ripple across all 8 serial steps.
- a=0xA5, b=0x5A -> sum=0xFF, cout=0. Then a=0x80, b=0x80 -> sum=0x00, cout=1, and sum holds 0xFF throughout the second RUN until its completion edge.
- Start pulsed again 3 cycles into RUN with different operands, and a/b changed mid-RUN -> ignored; the result matches the originally latched operands; exactly one done pulse.
- rst asserted asynchronously between edges during RUN -> busy, done, sum and cout go to 0 immediately (before the next edge); no done pulse; a subsequent start completes normally.
- start held high continuously with constant a=0x03, b=0x04 -> a done pulse every 10 cycles, sum=0x07 each time. Re-run with WIDTH=1: a=1, b=1 -> sum=0, cout=1, done in the cycle after edge E0+1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder controller: state encoding and
// the default operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder built from two half-adder stages and an OR.
// Purely combinational; the controller owns all state.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs1;
  logic hc1;
  logic hc2;

  // First half adder combines the operand bits, second folds in carry-in.
  assign hs1 = x ^ y;
  assign hc1 = x & y;
  assign s   = hs1 ^ ci;
  assign hc2 = hs1 & ci;
  assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Serial adder sequencer: latches two WIDTH-bit operands on start, then feeds
// one bit pair per cycle (LSB first) through a single full-adder cell,
// carrying between cycles. Result and carry-out are registered and held
// until the next completion.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             fa_s;
  logic             fa_co;

  // Shift a vector right by one, inserting a new bit at the MSB. Written
  // as a function so that WIDTH=1 needs no special-case slicing.
  function automatic logic [WIDTH-1:0] shr_in(input logic [WIDTH-1:0] v,
                                              input logic             msb);
    logic [WIDTH-1:0] r;
    r = v >> 1;
    r[WIDTH-1] = msb;
    return r;
  endfunction

  // The single shared adder cell always sees the current LSBs and carry.
  fa_cell u_fa (
    .x  (opa_q[0]),
    .y  (opb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // State and datapath registers; reset clears everything so an aborted
  // operation leaves no stale result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state and datapath sequencing: accept in IDLE, one bit per RUN
  // cycle, result commit on the last RUN edge, one-cycle DONE.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        psum_d  = shr_in(psum_q, fa_s);
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // The bit computed this cycle must be part of the committed sum.
          sum_d   = shr_in(psum_q, fa_s);
          cout_d  = fa_co;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int total = 0;
  int bad   = 0;

  logic [7:0] prev_sum  = 8'h00;
  logic       prev_cout = 1'b0;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 operation; optionally pulses start and scrambles a/b mid-RUN.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] es, input logic ec,
                        input bit disturb, input string tag);
    int n;
    int nbusy;
    int ndone;
    bit held;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    nbusy = 0;
    held = 1'b1;
    while (!done && n < 20) begin
      if (busy) nbusy++;
      if (sum !== prev_sum || cout !== prev_cout) held = 1'b0;
      if (disturb && n == 3) begin start = 1'b1; a = 8'h11; b = 8'h22; end
      if (disturb && n == 4) begin start = 1'b0; a = 8'hEE; b = 8'hDD; end
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"},   n, 8);
    chk({tag, "_nbusy"}, nbusy, 8);
    chk({tag, "_held"},  held, 1);
    chk({tag, "_done"},  done, 1);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_sum"},   sum, es);
    chk({tag, "_cout"},  cout, ec);
    prev_sum  = es;
    prev_cout = ec;
    ndone = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk({tag, "_onepulse"}, ndone, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    start1 = 1'b0;
    a1 = 1'b0;
    b1 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum",  sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_sum1",  sum1, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "zero");
    run_op(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "ripple");
    run_op(8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0, "alt");
    run_op(8'h80, 8'h80, 8'h00, 1'b1, 1'b0, "msb");
    run_op(8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b1, "ignore");

    // Asynchronous reset between edges during RUN.
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sum",  sum, 0);
    chk("arst_cout", cout, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst_post_busy", busy, 0);
    chk("arst_post_done", done, 0);
    prev_sum  = 8'h00;
    prev_cout = 1'b0;
    @(posedge clk); #1;
    run_op(8'h12, 8'h34, 8'h46, 1'b0, 1'b0, "after_rst");

    // Back-to-back operations with start held high.
    a = 8'h03;
    b = 8'h04;
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!done && n < 30);
      if (k > 0) chk("thr_period", n, 10);
      chk("thr_done", done, 1);
      chk("thr_sum",  sum, 8'h07);
      chk("thr_cout", cout, 0);
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("thr_idle_busy", busy, 0);

    // WIDTH=1 instance.
    a1 = 1'b1;
    b1 = 1'b1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("w1_busy", busy1, 1);
    chk("w1_sum_hold", sum1, 0);
    @(posedge clk); #1;
    chk("w1_done", done1, 1);
    chk("w1_sum",  sum1, 0);
    chk("w1_cout", cout1, 1);
    @(posedge clk); #1;
    chk("w1_done_end", done1, 0);
    a1 = 1'b1;
    b1 = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    chk("w1b_done", done1, 1);
    chk("w1b_sum",  sum1, 1);
    chk("w1b_cout", cout1, 0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
